// File: rtl/mod47_pkg.sv
// Shared constants and types for the mod-47 residue datapath.
package mod47_pkg;

  localparam int unsigned MOD47    = 47;
  localparam int unsigned SCALE400 = 24;  // 400 mod 47
  localparam int unsigned INV400   = 2;   // 24^-1 mod 47
  localparam int unsigned RW       = 6;

  typedef logic [RW-1:0] residue_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mod_dbl_add_step.sv
// One MSB-first double-and-add step: acc_next = (2*acc + (add_bit ? operand : 0)) mod MOD.
// Assumes acc < MOD and operand < MOD, so the sum is below 3*MOD and two
// conditional subtractions are enough.
module mod_dbl_add_step #(
  parameter int unsigned MOD = 47,
  parameter int unsigned RW  = 6
) (
  input  logic [RW-1:0] acc,
  input  logic [RW-1:0] operand,
  input  logic          add_bit,
  output logic [RW-1:0] acc_next
);

  localparam logic [RW+1:0] ModW = (RW+2)'(MOD);

  logic [RW+1:0] t;
  logic [RW+1:0] t1;

  // Double, optionally add, then reduce with two conditional subtractions.
  always_comb begin
    t        = {1'b0, acc, 1'b0} + (add_bit ? {2'b00, operand} : '0);
    t1       = (t >= ModW) ? (t - ModW) : t;
    acc_next = (t1 >= ModW) ? RW'(t1 - ModW) : RW'(t1);
  end

endmodule

// File: rtl/mod47_unscale_seq.sv
// Removes the x400 scale from a mod-47 residue by multiplying with the
// constant inverse, one KINV bit per cycle. Fixed KW-iteration latency.
module mod47_unscale_seq #(
  parameter int unsigned MOD  = mod47_pkg::MOD47,
  parameter int unsigned RW   = mod47_pkg::RW,
  parameter int unsigned KINV = mod47_pkg::INV400,
  parameter int unsigned KW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_res,
  output logic          out_err
);

  import mod47_pkg::*;

  localparam int unsigned   CW       = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [KW-1:0] KinvBits = KW'(KINV);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] opnd_q, opnd_d;
  logic          err_q, err_d;
  logic [RW-1:0] res_q, res_d;
  logic          oerr_q, oerr_d;
  logic          ovalid_q, ovalid_d;
  logic [RW-1:0] step_next;
  logic          load;

  mod_dbl_add_step #(
    .MOD(MOD),
    .RW (RW)
  ) u_step (
    .acc     (acc_q),
    .operand (opnd_q),
    .add_bit (KinvBits[cnt_q]),
    .acc_next(step_next)
  );

  // State register and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      err_q    <= 1'b0;
      res_q    <= '0;
      oerr_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      err_q    <= err_d;
      res_q    <= res_d;
      oerr_q   <= oerr_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Next-state: accept in IDLE or when the held result leaves, iterate in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    err_d    = err_q;
    res_d    = res_q;
    oerr_d   = oerr_q;
    ovalid_d = ovalid_q;
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        load = in_valid;
      end
      RUN: begin
        // Out-of-range operands never feed the reduction; result stays 0.
        acc_d = err_q ? '0 : step_next;
        if (cnt_q == '0) begin
          res_d    = acc_d;
          oerr_d   = err_q;
          ovalid_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
          load     = in_valid;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      opnd_d  = in_res;
      err_d   = (in_res >= RW'(MOD));
      acc_d   = '0;
      cnt_d   = CW'(KW - 1);
      state_d = RUN;
    end
  end

  // Outputs: in_ready depends only on state and out_ready; the rest are registered.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = ovalid_q;
    out_res   = res_q;
    out_err   = oerr_q;
  end

endmodule

// File: tb/tb_mod47_unscale_seq.sv
// Bench for mod47_unscale_seq: directed literal cases plus random handshakes
// checked every cycle against a transaction-level model.
module tb_mod47_unscale_seq;

  import mod47_pkg::*;

  localparam int KW    = 6;
  localparam int LAT   = KW + 1;
  localparam int NRAND = 2500;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     in_valid = 1'b0;
  logic     out_ready = 1'b0;
  residue_t in_res = '0;
  logic     in_ready;
  logic     out_valid;
  logic     out_err;
  residue_t out_res;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod47_unscale_seq #(
    .MOD (47),
    .RW  (6),
    .KINV(2),
    .KW  (KW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_res   (in_res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_err  (out_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_res(input int r);
    return (r >= 47) ? 0 : (r * 2) % 47;
  endfunction

  function automatic int ref_err(input int r);
    return (r >= 47) ? 1 : 0;
  endfunction

  // Transaction model: at most one result outstanding, visible LAT cycles after
  // its handshake and held until accepted.
  bit mon_en = 1'b0;
  bit have = 1'b0;
  bit fresh = 1'b1;
  bit mon_ev;
  bit mon_er;
  int due = 0;
  int m_res = 0;
  int m_err = 0;
  int results = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_ev = have && (cyc >= due);
      mon_er = !have || (mon_ev && out_ready);
      check("mon out_valid", 32'(out_valid), 32'(mon_ev));
      check("mon in_ready", 32'(in_ready), 32'(mon_er));
      if (mon_ev) begin
        check("mon out_res", 32'(out_res), m_res);
        check("mon out_err", 32'(out_err), m_err);
        fresh = 1'b0;
      end else if (fresh) begin
        check("mon reset out_res", 32'(out_res), 0);
        check("mon reset out_err", 32'(out_err), 0);
      end
      if (rst) begin
        have  = 1'b0;
        fresh = 1'b1;
      end else begin
        if (mon_ev && out_ready) begin
          have = 1'b0;
          results++;
        end
        if (in_valid && mon_er) begin
          have  = 1'b1;
          due   = cyc + LAT;
          m_res = ref_res(int'(in_res));
          m_err = ref_err(int'(in_res));
        end
      end
    end
  end

  // Present r, wait for the handshake, then time and check the result.
  task automatic send(input int r, input int exp_r, input int exp_e, input string nm);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_res   = r[5:0];
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    check({nm, " handshake"}, 32'(ok), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check({nm, " latency"}, n, LAT);
    check({nm, " out_res"}, 32'(out_res), exp_r);
    check({nm, " out_err"}, 32'(out_err), exp_e);
    @(posedge clk);
    #1;
  endtask

  bit rdone = 1'b0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_res", 32'(out_res), 0);
    check("reset out_err", 32'(out_err), 0);
    check("reset in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Literal expectations pinning the model.
    send(24, 1, 0, "r24");
    send(0, 0, 0, "r0");
    send(23, 46, 0, "r23");
    send(46, 45, 0, "r46");
    send(47, 0, 1, "r47");
    send(63, 0, 1, "r63");
    send(5, 10, 0, "r5");

    // Full sweep and forward-LUT round trip.
    for (int x = 0; x < 47; x++) send(x, (2 * x) % 47, 0, "sweep");
    for (int x = 0; x < 47; x++) send((x * 24) % 47, x, 0, "roundtrip");

    // Hold the result, then accept it in the same cycle a new input arrives.
    out_ready = 1'b0;
    send(24, 1, 0, "stall first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall out_valid", 32'(out_valid), 1);
      check("stall out_res", 32'(out_res), 1);
      check("stall out_err", 32'(out_err), 0);
      check("stall in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(30, 13, 0, "back2back");

    // Reset in the third RUN cycle discards the in-flight result.
    in_valid = 1'b1;
    in_res   = 6'd24;
    @(negedge clk);
    check("pre-reset in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrun rst out_valid", 32'(out_valid), 0);
    check("midrun rst out_res", 32'(out_res), 0);
    check("midrun rst out_err", 32'(out_err), 0);
    check("midrun rst in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no stale result", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;

    // Random traffic on both handshakes; the model checks every cycle.
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          int n;
          bit ok;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 in_valid = 1'b1;
          in_res = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(47, 63))
                                               : 6'($urandom_range(0, 46));
          ok = 1'b0;
          n  = 0;
          while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
          end
          if (!ok) check("random handshake timeout", 32'(ok), 1);
          @(posedge clk);
          #1 in_valid = 1'b0;
          in_res = 6'($urandom_range(0, 63));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drain nothing pending", 32'(have), 0);
    check("drain out_valid", 32'(out_valid), 0);
    check("result count", results, 1 + 6 + 47 + 47 + 2 + NRAND);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
